// File: rtl/stream_uart_tx.sv
// Stream-to-UART bridge: accepts 32-bit stb/ack words, queues the low byte of
// each in a circular FIFO and shifts it out as 8N1 asynchronous serial on tx.
module stream_uart_tx #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_AW         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      input_in,
  input  logic             input_in_stb,
  output logic             input_in_ack,
  output logic             tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int DIV   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(DEPTH);

  if (DIV < 2) begin : g_div_illegal
    $error("stream_uart_tx: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
  end
  if (FIFO_AW < 1) begin : g_aw_illegal
    $error("stream_uart_tx: FIFO_AW must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               push;
  logic               pop;

  // Only the low byte is serialised; the upper bits are deliberately dropped.
  logic [23:0] unused_hi;
  assign unused_hi = input_in[31:8];

  assign input_in_ack = (count_q != CNT_FULL) && !rst;
  assign push         = input_in_stb && input_in_ack;

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // tx and busy are computed from the current state and registered, so the
  // line lags the state register by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    busy_d  = (state_q != S_IDLE) || (count_q != '0);
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        tx_d = shift_q[idx_q];
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // Payload storage carries no reset; the count and pointers gate its use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wptr_q] <= input_in[7:0];
  end

endmodule
